// File: rtl/medidor_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 distance meter: state codes,
// timing defaults and BCD sizing, plus the debug-code helper.
package medidor_hcsr04_pkg;

    // Timing defaults for a 50 MHz clock
    localparam int TRIGGER_CICLOS_DEF = 500;        // 10 us trigger pulse
    localparam int CICLOS_POR_CM_DEF  = 2941;       // 58.82 us of echo per cm
    localparam int TIMEOUT_CICLOS_DEF = 1_500_000;  // 30 ms echo wait / echo width limit

    // Result format: three BCD digits {hundreds, tens, units}
    localparam int BCD_DIGITO_W = 4;
    localparam int MEDIDA_W     = 3 * BCD_DIGITO_W;

    // Encoded so that the state code is directly the debug code
    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARACAO    = 4'd1,
        ENVIA_TRIGGER = 4'd2,
        ESPERA_ECHO   = 4'd3,
        MEDE          = 4'd4,
        ARMAZENA      = 4'd5,
        FINAL_MEDIDA  = 4'd6,
        ERRO_ST       = 4'd7
    } estado_t;

    // Debug code for a state; any code outside the defined set reads as F
    function automatic logic [3:0] codigo_debug(estado_t e);
        case (e)
            INICIAL, PREPARACAO, ENVIA_TRIGGER, ESPERA_ECHO,
            MEDE, ARMAZENA, FINAL_MEDIDA, ERRO_ST: codigo_debug = e;
            default:                               codigo_debug = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/medidor_hcsr04_if.sv
// Signal bundle between the sonar control unit / sensor side and the meter.
//
// Handshake: the controller raises medir; it is only looked at while the
// meter is idle (db_estado == 0), so holding it high merely starts the next
// measurement once the current one is over. The meter answers every accepted
// request with exactly one single-cycle pronto. On that cycle medida holds the
// result (unchanged from before if erro is 1) and it stays valid until the
// next result is stored; erro stays valid until the next request is accepted.
interface medidor_hcsr04_if;
    import medidor_hcsr04_pkg::*;

    logic                medir;
    logic                echo;
    logic                trigger;
    logic [MEDIDA_W-1:0] medida;
    logic                pronto;
    logic                erro;
    logic [3:0]          db_estado;

    // Controller / sensor side
    modport master (
        output medir,
        output echo,
        input  trigger,
        input  medida,
        input  pronto,
        input  erro,
        input  db_estado
    );

    // Meter side
    modport slave (
        input  medir,
        input  echo,
        output trigger,
        output medida,
        output pronto,
        output erro,
        output db_estado
    );

endinterface

// File: rtl/medidor_hcsr04_contador_cm_bcd.sv
// Three-digit BCD centimetre counter. Clears on zera, advances by one on
// conta and sticks at 999 instead of wrapping.
module contador_cm_bcd
    import medidor_hcsr04_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                zera,
    input  logic                conta,
    output logic [MEDIDA_W-1:0] valor,
    output logic                fim_saturado
);

    logic [BCD_DIGITO_W-1:0] unidades;
    logic [BCD_DIGITO_W-1:0] dezenas;
    logic [BCD_DIGITO_W-1:0] centenas;

    assign valor        = {centenas, dezenas, unidades};
    assign fim_saturado = (centenas == 4'd9) && (dezenas == 4'd9) && (unidades == 4'd9);

    // Digit registers with decimal carry from units to tens to hundreds
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            unidades <= '0;
            dezenas  <= '0;
            centenas <= '0;
        end else if (zera) begin
            unidades <= '0;
            dezenas  <= '0;
            centenas <= '0;
        end else if (conta && !fim_saturado) begin
            if (unidades != 4'd9) begin
                unidades <= unidades + 1'b1;
            end else begin
                unidades <= '0;
                if (dezenas != 4'd9) begin
                    dezenas <= dezenas + 1'b1;
                end else begin
                    dezenas  <= '0;
                    centenas <= centenas + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/medidor_hcsr04.sv
// HC-SR04 driver: issues the trigger pulse on request, times the echo pulse
// and converts its width to centimetres (rounded to nearest) in BCD.
module medidor_hcsr04
    import medidor_hcsr04_pkg::*;
#(
    parameter int TRIGGER_CICLOS = TRIGGER_CICLOS_DEF,
    parameter int CICLOS_POR_CM  = CICLOS_POR_CM_DEF,
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
    input  logic              clock,
    input  logic              reset,
    medidor_hcsr04_if.slave   bus
);

    localparam int TRIG_W = (TRIGGER_CICLOS > 1) ? $clog2(TRIGGER_CICLOS) : 1;
    localparam int TICK_W = (CICLOS_POR_CM  > 1) ? $clog2(CICLOS_POR_CM)  : 1;
    localparam int TO_W   = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    localparam logic [TRIG_W-1:0] TRIG_MAX = TRIG_W'(TRIGGER_CICLOS - 1);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CICLOS_POR_CM - 1);
    // Starting the sub-centimetre phase at half a centimetre turns the
    // truncating count into round-to-nearest.
    localparam logic [TICK_W-1:0] TICK_INI = TICK_W'(CICLOS_POR_CM / 2);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CICLOS - 1);

    estado_t             estado;
    logic [TRIG_W-1:0]   trig_cnt;
    logic [TICK_W-1:0]   tick;
    logic [TO_W-1:0]     to_cnt;

    logic                echo_meta;
    logic                echo_sync;
    logic                echo_prev;
    logic                echo_borda;

    logic [MEDIDA_W-1:0] cm_valor;
    logic                cm_saturado;
    logic                ciclo_alto;
    logic                conta_cm;
    logic                zera_cm;

    // Two-flop synchroniser for the asynchronous echo pin, plus one more
    // stage so a rising edge can be recognised
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_meta <= 1'b0;
            echo_sync <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_meta <= bus.echo;
            echo_sync <= echo_meta;
            echo_prev <= echo_sync;
        end
    end

    assign echo_borda = echo_sync && !echo_prev;

    // A cycle of echo width that contributes to the distance: the edge cycle
    // in espera_echo and every further high cycle in mede short of the limit
    assign ciclo_alto = ((estado == ESPERA_ECHO) && echo_borda) ||
                        ((estado == MEDE) && echo_sync && (to_cnt != TO_MAX));
    assign conta_cm   = ciclo_alto && (tick == TICK_MAX) && !cm_saturado;
    assign zera_cm    = (estado == PREPARACAO);

    contador_cm_bcd u_contador_cm (
        .clock        (clock),
        .reset        (reset),
        .zera         (zera_cm),
        .conta        (conta_cm),
        .valor        (cm_valor),
        .fim_saturado (cm_saturado)
    );

    // Measurement sequencer with registered trigger/medida/pronto/erro and
    // the trigger, timeout and sub-centimetre counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= INICIAL;
            bus.trigger <= 1'b0;
            bus.medida  <= '0;
            bus.pronto  <= 1'b0;
            bus.erro    <= 1'b0;
            trig_cnt <= '0;
            tick     <= '0;
            to_cnt   <= '0;
        end else begin
            bus.pronto <= 1'b0;

            if (ciclo_alto) begin
                tick <= (tick == TICK_MAX) ? '0 : tick + 1'b1;
            end

            case (estado)
                INICIAL: begin
                    if (bus.medir) begin
                        estado <= PREPARACAO;
                    end
                end

                PREPARACAO: begin
                    trig_cnt    <= '0;
                    to_cnt      <= '0;
                    tick        <= TICK_INI;
                    bus.erro    <= 1'b0;
                    bus.trigger <= 1'b1;
                    estado      <= ENVIA_TRIGGER;
                end

                ENVIA_TRIGGER: begin
                    if (trig_cnt == TRIG_MAX) begin
                        bus.trigger <= 1'b0;
                        estado      <= ESPERA_ECHO;
                    end else begin
                        trig_cnt <= trig_cnt + 1'b1;
                    end
                end

                ESPERA_ECHO: begin
                    if (echo_borda) begin
                        // The edge cycle is the first high cycle of the echo
                        to_cnt <= TO_W'(1);
                        estado <= MEDE;
                    end else if (to_cnt == TO_MAX) begin
                        // erro is raised together with pronto so the
                        // controller sees the reason on the completion cycle
                        bus.erro   <= 1'b1;
                        bus.pronto <= 1'b1;
                        estado     <= ERRO_ST;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                MEDE: begin
                    if (!echo_sync) begin
                        estado <= ARMAZENA;
                    end else if (to_cnt == TO_MAX) begin
                        bus.erro   <= 1'b1;
                        bus.pronto <= 1'b1;
                        estado     <= ERRO_ST;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                ARMAZENA: begin
                    bus.medida <= cm_valor;
                    bus.pronto <= 1'b1;
                    estado     <= FINAL_MEDIDA;
                end

                FINAL_MEDIDA: begin
                    estado <= INICIAL;
                end

                ERRO_ST: begin
                    estado <= INICIAL;
                end

                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

    assign bus.db_estado = codigo_debug(estado);

endmodule

// File: tb/tb_medidor_hcsr04.sv
// Self-checking bench for medidor_hcsr04 with shortened timing parameters.
module tb_medidor_hcsr04;
    import medidor_hcsr04_pkg::*;

    localparam int TRIG = 20;
    localparam int CPC  = 5;
    localparam int TO   = 6000;
    localparam int W    = 13;   // {erro, medida}

    logic clock = 1'b0;
    logic reset;

    medidor_hcsr04_if bus ();

    medidor_hcsr04 #(
        .TRIGGER_CICLOS (TRIG),
        .CICLOS_POR_CM  (CPC),
        .TIMEOUT_CICLOS (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [11:0]  last_medida = 12'h000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: width n echo cycles (0 = no edge) -> {erro, medida}
    function automatic logic [W-1:0] ref_model(input int n);
        int v;
        logic [3:0] h, t, u;
        if (n == 0 || n >= TO) begin
            return {1'b1, last_medida};
        end
        v = (n + CPC / 2) / CPC;
        if (v > 999) v = 999;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        last_medida = {h, t, u};
        return {1'b0, last_medida};
    endfunction

    // Scoreboard monitor: pops on every pronto, checks erro one cycle later,
    // and checks the width of every completed trigger pulse
    logic [W-1:0] mon_e;
    logic         erro_pend = 1'b0;
    logic         erro_exp  = 1'b0;
    int           trig_len  = 0;

    always @(negedge clock) begin
        if (erro_pend) begin
            check("erro_after_pronto", {31'd0, bus.erro}, {31'd0, erro_exp});
            erro_pend = 1'b0;
        end
        if (reset) begin
            trig_len = 0;
        end else begin
            if (bus.pronto) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_pronto");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("medida", {20'd0, bus.medida}, {20'd0, mon_e[11:0]});
                    erro_pend = 1'b1;
                    erro_exp  = mon_e[12];
                end
            end
            if (bus.trigger) begin
                trig_len++;
            end else if (trig_len != 0) begin
                check("trigger_width", trig_len, TRIG);
                trig_len = 0;
            end
        end
    end

    // Driver tasks
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200 && bus.db_estado != 4'd0; k++) @(negedge clock);
        if (bus.db_estado != 4'd0) fail_now("wait_idle_timeout");
    endtask

    // n: echo width in cycles (0 = none); stuck: echo high from before the
    // request; hold: medir kept high for the whole measurement
    task automatic measure(input int n, input bit stuck, input bit hold);
        bit got;
        int k;
        wait_idle();
        exp_q.push_back(ref_model(stuck ? 0 : n));
        if (stuck) begin
            bus.echo = 1'b1;
            cycles(4);
        end
        bus.medir = 1'b1;
        cycles(1);
        check("prep_state", {28'd0, bus.db_estado}, 32'd1);
        check("trigger_lat1", {31'd0, bus.trigger}, 32'd0);
        if (!hold) bus.medir = 1'b0;
        cycles(1);
        check("trigger_lat2", {31'd0, bus.trigger}, 32'd1);
        check("erro_clear", {31'd0, bus.erro}, 32'd0);
        for (k = 0; k < TRIG + 5 && bus.trigger; k++) @(negedge clock);
        if (bus.trigger) fail_now("trigger_stuck");
        got = 1'b0;
        if (!stuck && n > 0) begin
            cycles($urandom_range(0, 5));
            bus.echo = 1'b1;
            for (int i = 0; i < n; i++) begin
                @(negedge clock);
                if (bus.pronto) begin
                    got = 1'b1;
                    break;
                end
            end
            bus.echo = 1'b0;
        end
        for (k = 0; k < 2 * TO + 100 && !got; k++) begin
            @(negedge clock);
            if (bus.pronto) got = 1'b1;
        end
        if (!got) begin
            fail_now("pronto_timeout");
        end else begin
            cycles(1);
            check("idle_after_pronto", {28'd0, bus.db_estado}, 32'd0);
        end
        bus.medir = 1'b0;
        bus.echo  = 1'b0;
        cycles(2);
        check("no_restart", {28'd0, bus.db_estado}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.medir = 1'b0;
        bus.echo  = 1'b0;
        cycles(3);
        check("rst_trigger", {31'd0, bus.trigger}, 32'd0);
        check("rst_state", {28'd0, bus.db_estado}, 32'd0);
        check("rst_medida", {20'd0, bus.medida}, 32'd0);
        check("rst_pronto", {31'd0, bus.pronto}, 32'd0);
        check("rst_erro", {31'd0, bus.erro}, 32'd0);
        reset = 1'b0;
        cycles(2);

        // Reset in the middle of a trigger pulse
        bus.medir = 1'b1;
        cycles(1);
        bus.medir = 1'b0;
        cycles(10);
        check("trigger_before_reset", {31'd0, bus.trigger}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("cut_trigger", {31'd0, bus.trigger}, 32'd0);
        check("cut_state", {28'd0, bus.db_estado}, 32'd0);
        check("cut_medida", {20'd0, bus.medida}, 32'd0);
        check("cut_pronto", {31'd0, bus.pronto}, 32'd0);
        cycles(2);
        reset = 1'b0;
        cycles(2);

        // Nominal and rounding boundaries
        measure(20 * CPC, 0, 0);
        measure(CPC / 2, 0, 0);
        measure(CPC / 2 + 1, 0, 0);
        measure(CPC + CPC / 2 + 1, 0, 0);

        // No echo, then echo stuck high before the trigger
        measure(0, 0, 0);
        measure(7 * CPC, 0, 0);
        measure(0, 1, 0);

        // Echo too long, and the longest accepted echo (saturates at 999)
        measure(TO, 0, 0);
        measure(TO - 1, 0, 0);

        // medir held high across a measurement, back-to-back, BCD carry
        measure(123 * CPC, 0, 1);
        measure(7 * CPC, 0, 0);
        measure(100 * CPC - CPC / 2 - 1, 0, 0);
        measure(100 * CPC - CPC / 2, 0, 0);

        // Random widths
        for (int i = 0; i < 25; i++) begin
            measure($urandom_range(1, 1200), 0, $urandom_range(0, 1) == 1);
        end

        cycles(5);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
